// File: rtl/game_phase_sequencer.sv
// Lock-game phase sequencer: role selection windows with retry/default timeout,
// power display hold, lock entry and ready/restart, with a visible countdown.
module game_phase_sequencer #(
  parameter int unsigned NUM_ROLES     = 2,
  parameter int unsigned POWER_W       = 2,
  parameter int unsigned SELECT_CYCLES = 500000000,
  parameter int unsigned SHOW_CYCLES   = 250000000,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned DEFAULT_POWER = 1,
  parameter int unsigned CNT_W         = 30,
  localparam int unsigned RoleW = (NUM_ROLES > 1) ? $clog2(NUM_ROLES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_ROLES-1:0]         role_sel,
  input  logic [POWER_W-1:0]           power_code,
  input  logic                         lock_done,
  output logic [2:0]                   state,
  output logic [RoleW-1:0]             active_role,
  output logic [NUM_ROLES-1:0]         picked,
  output logic [NUM_ROLES*POWER_W-1:0] power_table,
  output logic [CNT_W-1:0]             countdown,
  output logic                         timeout_pulse
);

  localparam int unsigned RetryW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  localparam logic [CNT_W-1:0]   SelLoad   = CNT_W'(SELECT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   ShowLoad  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [RetryW-1:0]  RetryLast = RetryW'(MAX_RETRIES - 1);
  localparam logic [POWER_W-1:0] DefPow    = POWER_W'(DEFAULT_POWER);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitRole = 3'd1,
    StSelect   = 3'd2,
    StShow     = 3'd3,
    StSetLock  = 3'd4,
    StReady    = 3'd5
  } state_e;

  state_e                         state_q, state_d;
  logic [RoleW-1:0]               role_q, role_d;
  logic [NUM_ROLES-1:0]           picked_q, picked_d;
  logic [NUM_ROLES*POWER_W-1:0]   ptab_q, ptab_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [RetryW-1:0]              retry_q, retry_d;
  logic                           pulse_q, pulse_d;

  logic                           sel_found;
  logic [RoleW-1:0]               sel_role;
  logic                           store;
  logic [POWER_W-1:0]             store_val;
  logic                           do_clear;

  always_comb begin
    state_d   = state_q;
    role_d    = role_q;
    picked_d  = picked_q;
    ptab_d    = ptab_q;
    cnt_d     = '0;
    retry_d   = retry_q;
    pulse_d   = 1'b0;
    store     = 1'b0;
    store_val = '0;
    do_clear  = 1'b0;
    sel_found = 1'b0;
    sel_role  = '0;

    // Scan downwards so the lowest eligible index is the last one written.
    for (int r = int'(NUM_ROLES) - 1; r >= 0; r--) begin
      if (role_sel[r] && !picked_q[r]) begin
        sel_found = 1'b1;
        sel_role  = RoleW'(r);
      end
    end

    if (abort) begin
      state_d  = StIdle;
      do_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          do_clear = 1'b1;
          if (start) state_d = StWaitRole;
        end
        StWaitRole: begin
          if (sel_found) begin
            role_d  = sel_role;
            cnt_d   = SelLoad;
            retry_d = '0;
            state_d = StSelect;
          end
        end
        StSelect: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (power_code != '0) begin
            store     = 1'b1;
            store_val = power_code;
          end else if (retry_q < RetryLast) begin
            retry_d = retry_q + 1'b1;
            cnt_d   = SelLoad;
          end else begin
            store     = 1'b1;
            store_val = DefPow;
            pulse_d   = 1'b1;
          end
        end
        StShow: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = (&picked_q) ? StSetLock : StWaitRole;
          end
        end
        StSetLock: begin
          if (lock_done) state_d = StReady;
        end
        StReady: begin
          if (start) begin
            state_d  = StIdle;
            do_clear = 1'b1;
          end
        end
        default: begin
          state_d  = StIdle;
          do_clear = 1'b1;
        end
      endcase
    end

    if (store) begin
      for (int r = 0; r < int'(NUM_ROLES); r++) begin
        if (RoleW'(r) == role_q) begin
          picked_d[r]                    = 1'b1;
          ptab_d[r*POWER_W +: POWER_W] = store_val;
        end
      end
      cnt_d   = ShowLoad;
      state_d = StShow;
    end

    if (do_clear) begin
      role_d   = '0;
      picked_d = '0;
      ptab_d   = '0;
      retry_d  = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      role_q   <= '0;
      picked_q <= '0;
      ptab_q   <= '0;
      cnt_q    <= '0;
      retry_q  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      role_q   <= role_d;
      picked_q <= picked_d;
      ptab_q   <= ptab_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      pulse_q  <= pulse_d;
    end
  end

  // Counter is zeroed outside SELECT/SHOW, so it can drive countdown directly.
  assign state         = state_q;
  assign active_role   = role_q;
  assign picked        = picked_q;
  assign power_table   = ptab_q;
  assign countdown     = cnt_q;
  assign timeout_pulse = pulse_q;

endmodule
